// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter that locks a single FIFO write port to one producer per burst.
// Grant rotates after each burst; bursts end on req_last or after BURST_MAX beats.
module fifo_wr_arbiter #(
    parameter int N_REQ     = 4,
    parameter int WIDTH     = 4,
    parameter int BURST_MAX = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ*WIDTH-1:0]   req_data,
    input  logic [N_REQ-1:0]         req_last,
    output logic [N_REQ-1:0]         req_ready,
    output logic [WIDTH-1:0]         fifo_wdata,
    output logic                     fifo_wr_en,
    input  logic                     fifo_full,
    output logic                     grant_valid,
    output logic [$clog2(N_REQ)-1:0] grant_id
);

    localparam int IDW = $clog2(N_REQ);
    localparam int IW  = IDW + 1;
    localparam int BCW = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [IDW-1:0]   gnt_q, gnt_d;
    logic [IDW-1:0]   rr_q, rr_d;
    logic [BCW-1:0]   beat_q, beat_d;

    logic             pick_found;
    logic [IDW-1:0]   pick_idx;
    logic [IW-1:0]    scan_sum;
    logic [IDW-1:0]   scan_idx;

    logic [WIDTH-1:0] gnt_data;
    logic             xfer;
    logic             burst_end;
    logic [IDW-1:0]   gnt_next;

    // Valid/ready: a beat of producer i moves exactly on a cycle where
    // req_valid[i] && req_ready[i]; req_ready only rises for the granted
    // producer while the FIFO has room, so fifo_wr_en mirrors that handshake.

    // First requester at or after rr_q, modulo N_REQ.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        scan_sum   = '0;
        scan_idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            scan_sum = {1'b0, rr_q} + IW'(k);
            if (scan_sum >= IW'(N_REQ)) begin
                scan_sum = scan_sum - IW'(N_REQ);
            end
            scan_idx = scan_sum[IDW-1:0];
            if (!pick_found && req_valid[scan_idx]) begin
                pick_found = 1'b1;
                pick_idx   = scan_idx;
            end
        end
    end

    always_comb begin
        gnt_data  = req_data[int'(gnt_q)*WIDTH +: WIDTH];
        xfer      = (state_q == BURST) && req_valid[gnt_q] && !fifo_full;
        burst_end = xfer && (req_last[gnt_q] || (beat_q == BCW'(BURST_MAX - 1)));
        gnt_next  = (gnt_q == IDW'(N_REQ - 1)) ? '0 : gnt_q + IDW'(1);
    end

    always_comb begin
        req_ready = '0;
        if ((state_q == BURST) && !fifo_full) begin
            req_ready[gnt_q] = 1'b1;
        end
        fifo_wr_en  = xfer;
        fifo_wdata  = xfer ? gnt_data : '0;
        grant_valid = (state_q == BURST);
        grant_id    = gnt_q;
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        rr_d    = rr_q;
        beat_d  = beat_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d = BURST;
                    gnt_d   = pick_idx;
                    beat_d  = '0;
                end
            end
            BURST: begin
                // A stalled or empty cycle holds everything: the grant has no timeout.
                if (burst_end) begin
                    state_d = IDLE;
                    rr_d    = gnt_next;
                end else if (xfer) begin
                    beat_d = beat_q + BCW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            rr_q    <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            rr_q    <= rr_d;
            beat_q  <= beat_d;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios with literal expectations plus a
// randomized phase, all checked every cycle against a behavioural arbiter/FIFO model.
module tb_fifo_wr_arbiter;

    localparam int N   = 4;
    localparam int W   = 4;
    localparam int BM  = 4;
    localparam int IDW = 2;
    localparam int FIFO_DEPTH = 8;

    // ---------------- clock / reset / DUT ----------------
    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [N*W-1:0] req_data = '0;
    logic [N-1:0]   req_last = '0;
    logic [N-1:0]   req_ready;
    logic [W-1:0]   fifo_wdata;
    logic           fifo_wr_en;
    logic           fifo_full = 1'b0;
    logic           grant_valid;
    logic [IDW-1:0] grant_id;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(.N_REQ(N), .WIDTH(W), .BURST_MAX(BM)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_last   (req_last),
        .req_ready  (req_ready),
        .fifo_wdata (fifo_wdata),
        .fifo_wr_en (fifo_wr_en),
        .fifo_full  (fifo_full),
        .grant_valid(grant_valid),
        .grant_id   (grant_id)
    );

    // ---------------- bench state ----------------
    typedef struct packed {
        logic [W-1:0] data;
        logic         last;
    } beat_t;

    beat_t        prod_q[N][$];
    logic [W-1:0] exp_q[$];
    logic [W-1:0] fifo_q[$];

    int n_cmp = 0;
    int n_bad = 0;

    // Model of the arbiter: who owns the write port, who has priority next, beats so far.
    bit m_busy;
    int m_owner;
    int m_prio;
    int m_beats;

    int       valid_pct  = 100;
    int       drain_pct  = 100;
    bit [N-1:0] valid_mask = '1;
    bit       full_force = 1'b0;

    logic [N-1:0]   obs_ready;
    logic           obs_wr;
    logic           obs_gv;
    logic [W-1:0]   obs_wdata;
    logic [IDW-1:0] obs_gid;

    int wr_data[16];
    int wr_cyc[16];
    int wr_gid[16];
    int nw;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy  = 1'b0;
        m_owner = 0;
        m_prio  = 0;
        m_beats = 0;
    endtask

    task automatic push_burst(input int p, input int first_data, input int len);
        beat_t b;
        for (int k = 0; k < len; k++) begin
            b.data = W'(first_data + k);
            b.last = (k == len - 1);
            prod_q[p].push_back(b);
        end
    endtask

    // ---------------- driver ----------------
    task automatic drive_inputs();
        for (int i = 0; i < N; i++) begin
            if (prod_q[i].size() > 0 && valid_mask[i] &&
                $urandom_range(1, 100) <= valid_pct) begin
                req_valid[i]       = 1'b1;
                req_data[i*W +: W] = prod_q[i][0].data;
                req_last[i]        = prod_q[i][0].last;
            end else begin
                req_valid[i]       = 1'b0;
                req_data[i*W +: W] = W'($urandom_range(0, 15));
                req_last[i]        = 1'b0 | 1'($urandom_range(0, 1));
            end
        end
        fifo_full = (fifo_q.size() >= FIFO_DEPTH) || full_force;
    endtask

    // One clock: drive, compare against the model mid-cycle, then advance everything.
    task automatic step();
        logic [N-1:0] e_ready;
        logic         e_wr;
        logic [W-1:0] e_wdata;
        logic         e_gv;
        int           e_gid;
        bit           take;
        bit           n_busy;
        int           n_owner, n_prio, n_beats, acc, idx;
        logic [W-1:0] got;

        drive_inputs();
        @(negedge clk);
        e_ready = '0;
        e_wr    = 1'b0;
        e_wdata = '0;
        e_gv    = 1'b0;
        e_gid   = m_owner;
        take    = 1'b0;
        if (!rst_n) begin
            e_gid = 0;
        end else if (m_busy) begin
            e_gv = 1'b1;
            if (!fifo_full) e_ready[m_owner] = 1'b1;
            take = req_valid[m_owner] && !fifo_full;
            if (take) begin
                e_wr    = 1'b1;
                e_wdata = req_data[m_owner*W +: W];
            end
        end
        check("req_ready",   int'(req_ready),   int'(e_ready));
        check("fifo_wr_en",  int'(fifo_wr_en),  int'(e_wr));
        check("fifo_wdata",  int'(fifo_wdata),  int'(e_wdata));
        check("grant_valid", int'(grant_valid), int'(e_gv));
        check("grant_id",    int'(grant_id),    e_gid);
        obs_ready = req_ready;
        obs_wr    = fifo_wr_en;
        obs_gv    = grant_valid;
        obs_wdata = fifo_wdata;
        obs_gid   = grant_id;

        n_busy  = m_busy;
        n_owner = m_owner;
        n_prio  = m_prio;
        n_beats = m_beats;
        acc     = -1;
        if (!rst_n) begin
            n_busy = 0; n_owner = 0; n_prio = 0; n_beats = 0;
        end else if (!m_busy) begin
            for (int k = 0; k < N; k++) begin
                idx = (m_prio + k) % N;
                if (!n_busy && req_valid[idx]) begin
                    n_busy  = 1'b1;
                    n_owner = idx;
                    n_beats = 0;
                end
            end
        end else if (take) begin
            acc = m_owner;
            if (req_last[m_owner] || m_beats == BM - 1) begin
                n_busy = 1'b0;
                n_prio = (m_owner + 1) % N;
            end else begin
                n_beats = m_beats + 1;
            end
        end

        @(posedge clk);
        #1;
        m_busy  = n_busy;
        m_owner = n_owner;
        m_prio  = n_prio;
        m_beats = n_beats;
        if (acc >= 0) begin
            exp_q.push_back(prod_q[acc][0].data);
            void'(prod_q[acc].pop_front());
        end
        if (obs_wr) fifo_q.push_back(obs_wdata);
        if (fifo_q.size() > 0 && $urandom_range(1, 100) <= drain_pct) begin
            got = fifo_q.pop_front();
            if (exp_q.size() == 0) check("fifo_extra_beat", int'(got), -1);
            else                   check("fifo_order", int'(got), int'(exp_q.pop_front()));
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        for (int i = 0; i < N; i++) prod_q[i].delete();
        full_force = 1'b0;
        valid_mask = '1;
        valid_pct  = 100;
        drain_pct  = 100;
        #1;
        check("async_rst_gv", int'(grant_valid), 0);
        check("async_rst_wr", int'(fifo_wr_en), 0);
        for (int k = 0; k < 20 && (k < 2 || fifo_q.size() > 0); k++) step();
        rst_n = 1'b1;
    endtask

    task automatic run_record(input int cycles);
        nw = 0;
        for (int c = 0; c < cycles; c++) begin
            step();
            if (obs_wr && nw < 16) begin
                wr_data[nw] = int'(obs_wdata);
                wr_cyc[nw]  = c;
                wr_gid[nw]  = int'(obs_gid);
                nw++;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_rr[5];
        int exp_cap_d[7];
        int exp_cap_c[7];
        int exp_full_c[5];
        int exp_bub_c[5];
        int exp_bub_d[5];
        int guard;
        bit busy_left;

        exp_rr     = '{0, 1, 2, 3, 0};
        exp_cap_d  = '{1, 2, 3, 4, 9, 5, 6};
        exp_cap_c  = '{1, 2, 3, 4, 6, 8, 9};
        exp_full_c = '{1, 2, 6, 7, 9};
        exp_bub_c  = '{1, 2, 8, 9, 11};
        exp_bub_d  = '{1, 2, 3, 4, 7};

        model_reset();
        do_reset();

        // Reset held with every producer valid: outputs must stay quiet.
        rst_n = 1'b0;
        model_reset();
        for (int i = 0; i < N; i++) begin
            push_burst(i, 2*i + 1, 1);
            push_burst(i, 2*i + 2, 1);
        end
        for (int k = 0; k < 2; k++) begin
            step();
            check("rst_hold_valid", int'(req_valid), 15);
            check("rst_hold_gv",    int'(obs_gv), 0);
            check("rst_hold_wr",    int'(obs_wr), 0);
            check("rst_hold_ready", int'(obs_ready), 0);
            check("rst_hold_wdata", int'(obs_wdata), 0);
            check("rst_hold_gid",   int'(obs_gid), 0);
        end
        rst_n = 1'b1;

        // Round robin with single-beat bursts: one write every two cycles.
        run_record(10);
        check("rr_writes", nw, 5);
        for (int k = 0; k < 5; k++) check("rr_gid_seq", wr_gid[k], exp_rr[k]);
        check("rr_first_write_cycle", wr_cyc[0], 1);

        // Burst cap: a 6-beat burst is cut after 4 beats, producer 3 slips in.
        do_reset();
        push_burst(2, 1, 6);
        push_burst(3, 9, 1);
        run_record(12);
        check("cap_writes", nw, 7);
        for (int k = 0; k < 7; k++) begin
            check("cap_data", wr_data[k], exp_cap_d[k]);
            check("cap_cycle", wr_cyc[k], exp_cap_c[k]);
        end

        // FIFO full for 3 cycles mid-burst: stall, then resume without loss.
        do_reset();
        push_burst(1, 10, 5);
        nw = 0;
        for (int c = 0; c < 12; c++) begin
            full_force = (c >= 3 && c <= 5);
            step();
            if (c >= 3 && c <= 5) begin
                check("full_wr",    int'(obs_wr), 0);
                check("full_ready", int'(obs_ready), 0);
                check("full_gv",    int'(obs_gv), 1);
            end
            if (obs_wr && nw < 16) begin
                wr_data[nw] = int'(obs_wdata);
                wr_cyc[nw]  = c;
                nw++;
            end
        end
        full_force = 1'b0;
        check("full_writes", nw, 5);
        for (int k = 0; k < 5; k++) begin
            check("full_data", wr_data[k], 10 + k);
            check("full_cycle", wr_cyc[k], exp_full_c[k]);
        end

        // Bubble: producer 0 drops valid for 5 cycles, producer 3 must wait.
        do_reset();
        push_burst(0, 1, 4);
        push_burst(3, 7, 1);
        nw = 0;
        for (int c = 0; c < 13; c++) begin
            valid_mask = (c >= 3 && c <= 7) ? 4'b1110 : 4'b1111;
            step();
            if (c >= 3 && c <= 7) begin
                check("bubble_gid",    int'(obs_gid), 0);
                check("bubble_gv",     int'(obs_gv), 1);
                check("bubble_ready3", int'(obs_ready[3]), 0);
                check("bubble_wr",     int'(obs_wr), 0);
            end
            if (obs_wr && nw < 16) begin
                wr_data[nw] = int'(obs_wdata);
                wr_cyc[nw]  = c;
                nw++;
            end
        end
        valid_mask = '1;
        check("bubble_writes", nw, 5);
        for (int k = 0; k < 5; k++) begin
            check("bubble_data", wr_data[k], exp_bub_d[k]);
            check("bubble_cycle", wr_cyc[k], exp_bub_c[k]);
        end

        // Reset mid-burst: priority returns to producer 0.
        do_reset();
        push_burst(2, 5, 1);
        step();
        step();
        push_burst(1, 1, 4);
        for (int c = 0; c < 3; c++) step();
        check("midrst_pre_gid", int'(obs_gid), 1);
        check("midrst_pre_wr",  int'(obs_wr), 1);
        rst_n = 1'b0;
        model_reset();
        #1;
        check("midrst_async_gv", int'(grant_valid), 0);
        check("midrst_async_wr", int'(fifo_wr_en), 0);
        push_burst(0, 8, 1);
        push_burst(3, 6, 1);
        step();
        step();
        rst_n = 1'b1;
        step();
        step();
        check("midrst_win_gid",   int'(obs_gid), 0);
        check("midrst_win_wdata", int'(obs_wdata), 8);
        for (int c = 0; c < 12; c++) step();

        // Randomized traffic with a slowly draining 8-deep FIFO.
        valid_pct = 70;
        drain_pct = 40;
        for (int c = 0; c < 1500; c++) begin
            step();
            for (int i = 0; i < N; i++) begin
                if (prod_q[i].size() < 4 && $urandom_range(0, 3) == 0) begin
                    push_burst(i, int'($urandom_range(0, 15)), int'($urandom_range(1, 6)));
                end
            end
        end

        // Flush everything that is still pending.
        valid_pct = 100;
        drain_pct = 100;
        guard = 0;
        busy_left = 1'b1;
        while (busy_left && guard < 400) begin
            step();
            guard++;
            busy_left = (fifo_q.size() > 0);
            for (int i = 0; i < N; i++) if (prod_q[i].size() > 0) busy_left = 1'b1;
        end
        check("flush_done", int'(busy_left), 0);
        check("exp_q_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-port arbiter that shares one single-clock FIFO between N_REQ producers. Each producer presents a valid/ready stream with an end-of-burst marker. The arbiter locks the FIFO write port to one producer for a burst, then rotates priority. It sits directly in front of the FIFO write side (wdata / wr_en / full) in the communication datapath.

## Interface
Parameters:
- N_REQ, 4, number of producers (≥2)
- WIDTH, 4, data width; must match FIFO WIDTH
- BURST_MAX, 4, maximum beats per grant (≥1)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  N_REQ  producer i has a beat on req_data
- req_data  in  N_REQ*WIDTH  producer i data in bits [i*WIDTH +: WIDTH]
- req_last  in  N_REQ  producer i's current beat ends its burst
- req_ready  out  N_REQ  beat of producer i accepted this cycle when valid&ready
- fifo_wdata  out  WIDTH  to FIFO wdata
- fifo_wr_en  out  1  to FIFO wr_en
- fifo_full  in  1  from FIFO full
- grant_valid  out  1  a burst is currently granted
- grant_id  out  max(1,$clog2(N_REQ))  index of granted producer (valid when grant_valid)

## Operation
- State machine: IDLE, BURST. Registers: state, gnt (grant index), rr_ptr (highest-priority index), beat_cnt (max(1,$clog2(BURST_MAX)) bits).
- Reset values: state=IDLE, gnt=0, rr_ptr=0, beat_cnt=0. Outputs during/after reset: req_ready=0, fifo_wr_en=0, fifo_wdata=0, grant_valid=0, grant_id=0.
- IDLE: if any req_valid, select the first set bit scanning rr_ptr, rr_ptr+1, … modulo N_REQ. Latch it into gnt, clear beat_cnt, go to BURST. If none, stay in IDLE. No transfers occur in IDLE.
- BURST: req_ready[gnt] = !fifo_full. All other req_ready bits are 0.
- Transfer condition: req_valid[gnt] && !fifo_full. In that cycle fifo_wr_en=1 and fifo_wdata=req_data[gnt]. Otherwise fifo_wr_en=0 and fifo_wdata=0.
- End of burst: a transfer with req_last[gnt]=1, or a transfer with beat_cnt==BURST_MAX-1. Either one returns the FSM to IDLE and sets rr_ptr=(gnt+1) mod N_REQ, wrapping to 0 after N_REQ-1.
- Other transfers increment beat_cnt.
- Grant lock: while in BURST, a deasserted req_valid[gnt] holds the grant with no timeout. Bubbles are allowed, and other producers wait.
- fifo_full: the arbiter never asserts fifo_wr_en while fifo_full=1, so no beat is lost. A stalled burst resumes on the first cycle with fifo_full=0.
- grant_valid = (state==BURST). grant_id = gnt.
- req_last on a beat that does not transfer has no effect.
- Forced termination at BURST_MAX happens regardless of req_last. The producer's remaining beats compete again in a later arbitration.
- Asynchronous reset mid-burst: immediately returns to the reset values. Beats not yet transferred are the producer's responsibility; no partial state is retained.

## Timing
- Arbitration latency: a req_valid first seen in IDLE at cycle t gives grant_valid=1 at t+1. The first beat can transfer at t+1.
- Throughput in BURST: one beat per cycle while valid and !fifo_full.
- Burst turnaround: the end-of-burst transfer at cycle k puts the FSM in IDLE at k+1, and the next burst is granted at k+2. There is exactly one dead cycle between bursts.
- fifo_wr_en, fifo_wdata and req_ready are combinational from registered state plus req_valid, req_data and fifo_full. There is no combinational path from fifo_full to the grant registers other than through the transfer condition.
- All state updates occur on rising clk. Reset acts asynchronously on assertion and is released synchronously by the design flow.

## Test plan
- Reset: hold rst_n=0 with all req_valid=1. Required: all outputs 0, no fifo_wr_en. Release reset: grant_valid=1, grant_id=0 one cycle later.
- Round-robin, N_REQ=4, BURST_MAX=4: all producers send 1-beat bursts (req_last=1) continuously. Required: grant_id sequence 0,1,2,3,0 and one FIFO write every 2 cycles.
- Burst cap: producer 2 sends 6 beats, with req_last only on the 6th. Required: 4 beats written, IDLE, other requesters served, then producer 2's remaining 2 beats written in order.
- FIFO full: assert fifo_full for 3 cycles mid-burst. Required: fifo_wr_en=0 and req_ready[gnt]=0 for those cycles, beat_cnt unchanged, and the burst completes with no lost or duplicated data. Check against a model of an 8-deep FIFO filled to full.
- Bubble lock: the granted producer drops valid for 5 cycles while producer 3 requests. Required: grant_id unchanged, producer 3's req_ready=0, and the burst resumes.
- Reset mid-burst: assert rst_n=0 after 2 beats. Required: grant_valid=0 asynchronously and rr_ptr=0 afterwards, so producer 0 wins the next arbitration.
